// File: rtl/reg_scoreboard_pkg.sv
// Shared types for the register scoreboard: file selector, source/destination
// request bundle and a small file-mux helper.
package reg_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic {
    RF_INT = 1'b0,
    RF_FP  = 1'b1
  } reg_file_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic                  is_float;
    logic                  used;
  } sb_req_t;

  function automatic logic sel_file(input logic is_float, input logic int_v,
                                    input logic fp_v);
    return (reg_file_e'(is_float) == RF_FP) ? fp_v : int_v;
  endfunction

endpackage

// File: rtl/reg_scoreboard_sb_file.sv
// Pending-bit vector for one register file, with same-cycle completion bypass
// on the rs1/rs2/rd lookups.
module reg_scoreboard_sb_file #(
  parameter int                        NUM_REGS = reg_scoreboard_pkg::NUM_REGS,
  parameter reg_scoreboard_pkg::reg_file_e FILE = reg_scoreboard_pkg::RF_INT,
  localparam int                       AW       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_set,
  input  logic [AW-1:0]       i_set_addr,
  input  logic                i_clr,
  input  logic [AW-1:0]       i_clr_addr,
  input  logic [AW-1:0]       i_rs1_addr,
  input  logic [AW-1:0]       i_rs2_addr,
  input  logic [AW-1:0]       i_rd_addr,
  output logic [NUM_REGS-1:0] o_pending,
  output logic                o_rs1_eff,
  output logic                o_rs2_eff,
  output logic                o_rd_eff,
  output logic                o_clr_hit
);
  import reg_scoreboard_pkg::*;

  localparam logic [NUM_REGS-1:0] ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};
  // Integer x0 is hardwired: its bit can never be set.
  localparam logic [NUM_REGS-1:0] KEEP_MASK =
    {{(NUM_REGS-1){1'b1}}, (FILE == RF_FP)};

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_set_mask;
  logic [NUM_REGS-1:0] w_clr_mask;

  function automatic logic eff_lookup(input logic [NUM_REGS-1:0] pend,
                                      input logic clr, input logic [AW-1:0] clr_addr,
                                      input logic [AW-1:0] addr);
    return pend[addr] & ~(clr & (clr_addr == addr));
  endfunction

  assign w_set_mask = i_set ? ((ONE << i_set_addr) & KEEP_MASK) : '0;
  assign w_clr_mask = i_clr ? (ONE << i_clr_addr) : '0;

  // Clear is applied before set so a same-register issue/completion ends pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end
  end

  assign o_pending = r_pending;
  assign o_rs1_eff = eff_lookup(r_pending, i_clr, i_clr_addr, i_rs1_addr);
  assign o_rs2_eff = eff_lookup(r_pending, i_clr, i_clr_addr, i_rs2_addr);
  assign o_rd_eff  = eff_lookup(r_pending, i_clr, i_clr_addr, i_rd_addr);
  assign o_clr_hit = i_clr & r_pending[i_clr_addr];

endmodule

// File: rtl/reg_scoreboard.sv
// ID-stage scoreboard for long-latency results: RAW/WAW/capacity stall,
// outstanding-op counter and sticky stray-completion flag.
module reg_scoreboard #(
  parameter int  NUM_REGS        = reg_scoreboard_pkg::NUM_REGS,
  parameter int  MAX_OUTSTANDING = 4,
  localparam int AW              = $clog2(NUM_REGS),
  localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic                issue_long,
  input  logic                issue_rd_we,
  input  logic                issue_rd_is_float,
  input  logic [AW-1:0]       issue_rd_addr,
  input  logic [AW-1:0]       issue_rs1_addr,
  input  logic                issue_rs1_is_float,
  input  logic                issue_rs1_used,
  input  logic [AW-1:0]       issue_rs2_addr,
  input  logic                issue_rs2_is_float,
  input  logic                issue_rs2_used,
  input  logic                flush,
  input  logic                cmpl_valid,
  input  logic                cmpl_is_float,
  input  logic [AW-1:0]       cmpl_rd_addr,
  output logic                stall,
  output logic [NUM_REGS-1:0] int_pending,
  output logic [NUM_REGS-1:0] fp_pending,
  output logic [CW-1:0]       pending_cnt,
  output logic                cmpl_err
);
  import reg_scoreboard_pkg::*;

  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTSTANDING);

  sb_req_t w_rs1;
  sb_req_t w_rs2;
  sb_req_t w_rd;

  logic w_int_set, w_fp_set;
  logic w_int_clr, w_fp_clr;
  logic w_int_rs1, w_int_rs2, w_int_rd, w_int_hit;
  logic w_fp_rs1, w_fp_rs2, w_fp_rd, w_fp_hit;
  logic w_clr_hit;
  logic w_raw, w_waw, w_full;
  logic w_rd_x0;
  logic w_accept;

  logic [CW-1:0] r_cnt;
  logic          r_err;

  assign w_rs1 = '{addr: REG_ADDR_W'(issue_rs1_addr), is_float: issue_rs1_is_float,
                   used: issue_rs1_used};
  assign w_rs2 = '{addr: REG_ADDR_W'(issue_rs2_addr), is_float: issue_rs2_is_float,
                   used: issue_rs2_used};
  assign w_rd  = '{addr: REG_ADDR_W'(issue_rd_addr), is_float: issue_rd_is_float,
                   used: issue_rd_we};

  assign w_int_clr = cmpl_valid & (reg_file_e'(cmpl_is_float) == RF_INT);
  assign w_fp_clr  = cmpl_valid & (reg_file_e'(cmpl_is_float) == RF_FP);
  assign w_int_set = w_accept & ~w_rd.is_float;
  assign w_fp_set  = w_accept & w_rd.is_float;

  reg_scoreboard_sb_file #(.NUM_REGS(NUM_REGS), .FILE(RF_INT)) u_int_file (
    .clk        (clk),
    .rst        (rst),
    .i_set      (w_int_set),
    .i_set_addr (issue_rd_addr),
    .i_clr      (w_int_clr),
    .i_clr_addr (cmpl_rd_addr),
    .i_rs1_addr (AW'(w_rs1.addr)),
    .i_rs2_addr (AW'(w_rs2.addr)),
    .i_rd_addr  (AW'(w_rd.addr)),
    .o_pending  (int_pending),
    .o_rs1_eff  (w_int_rs1),
    .o_rs2_eff  (w_int_rs2),
    .o_rd_eff   (w_int_rd),
    .o_clr_hit  (w_int_hit)
  );

  reg_scoreboard_sb_file #(.NUM_REGS(NUM_REGS), .FILE(RF_FP)) u_fp_file (
    .clk        (clk),
    .rst        (rst),
    .i_set      (w_fp_set),
    .i_set_addr (issue_rd_addr),
    .i_clr      (w_fp_clr),
    .i_clr_addr (cmpl_rd_addr),
    .i_rs1_addr (AW'(w_rs1.addr)),
    .i_rs2_addr (AW'(w_rs2.addr)),
    .i_rd_addr  (AW'(w_rd.addr)),
    .o_pending  (fp_pending),
    .o_rs1_eff  (w_fp_rs1),
    .o_rs2_eff  (w_fp_rs2),
    .o_rd_eff   (w_fp_rd),
    .o_clr_hit  (w_fp_hit)
  );

  assign w_clr_hit = w_int_hit | w_fp_hit;

  // Hazards use the bypassed view: a result completing this cycle is forwarded.
  assign w_raw = (w_rs1.used & sel_file(w_rs1.is_float, w_int_rs1, w_fp_rs1)) |
                 (w_rs2.used & sel_file(w_rs2.is_float, w_int_rs2, w_fp_rs2));
  assign w_waw = w_rd.used & sel_file(w_rd.is_float, w_int_rd, w_fp_rd);
  assign w_full = issue_long & issue_rd_we &
                  ((r_cnt - CW'(w_clr_hit)) == MAX_C);

  assign stall = issue_valid & ~flush & (w_raw | w_waw | w_full);

  assign w_rd_x0  = ~issue_rd_is_float & (issue_rd_addr == '0);
  assign w_accept = issue_valid & ~flush & ~stall & issue_long & issue_rd_we & ~w_rd_x0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= r_cnt + CW'(w_accept) - CW'(w_clr_hit);
      r_err <= r_err | (cmpl_valid & ~w_clr_hit);
    end
  end

  assign pending_cnt = r_cnt;
  assign cmpl_err    = r_err;

  a_cnt_bound : assert property (@(posedge clk) disable iff (rst) (r_cnt <= MAX_C));

endmodule
